// File: rtl/blob_pkg.sv
// blob_pkg: shared frame geometry defaults, luma weights, binarizer FSM
// states and the luma helper. Also consumed by the downstream blob counter.
package blob_pkg;

  localparam int IMG_COL_DEF = 640;
  localparam int IMG_ROW_DEF = 480;

  // Y = (2R + 5G + B) >> 3; the 13-bit sum cannot overflow for 10-bit inputs
  localparam logic [12:0] LUMA_WR = 13'd2;
  localparam logic [12:0] LUMA_WG = 13'd5;
  localparam logic [12:0] LUMA_WB = 13'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_ABORT
  } bin_state_t;

  function automatic logic [9:0] luma_y(input logic [9:0] r,
                                        input logic [9:0] g,
                                        input logic [9:0] b);
    logic [12:0] sum;
    sum = LUMA_WR * {3'b000, r} + LUMA_WG * {3'b000, g} + LUMA_WB * {3'b000, b};
    return sum[12:3];
  endfunction

endpackage

// File: rtl/pixel_luma_thresh.sv
// pixel_luma_thresh: two-stage RGB -> luma -> binary pixel pipeline.
// Stage 1 registers the luma, stage 2 registers the threshold compare.
module pixel_luma_thresh
  import blob_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_r,
  input  logic [9:0] i_g,
  input  logic [9:0] i_b,
  input  logic [9:0] i_thresh,
  output logic       o_bin
);

  logic [9:0] y_reg;

  // Stage 1: weighted luma of the incoming pixel
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) y_reg <= '0;
    else       y_reg <= luma_y(i_r, i_g, i_b);
  end

  // Stage 2: strict greater-than compare against the frame threshold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_bin <= 1'b0;
    else       o_bin <= (y_reg > i_thresh);
  end

endmodule

// File: rtl/pixel_binarizer.sv
// pixel_binarizer: frames a CCD RGB stream, thresholds luma per pixel and
// emits a continuous o_valid envelope per complete frame for the blob counter.
// Optional build macro BINARIZER_MAJ3_EN adds a 3-tap horizontal majority
// filter on the binary pixels (one extra cycle of latency, edge columns = 0).
module pixel_binarizer
  import blob_pkg::*;
#(
  parameter int IMG_COL = IMG_COL_DEF,
  parameter int IMG_ROW = IMG_ROW_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_sof,
  input  logic [9:0] i_r,
  input  logic [9:0] i_g,
  input  logic [9:0] i_b,
  input  logic [9:0] i_thresh,
  output logic       o_valid,
  output logic       o_seq,
  output logic       o_err,
  output logic       o_frame_done
);

`ifdef BINARIZER_MAJ3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [9:0] COL_LAST = 10'(IMG_COL - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_ROW - 1);

  bin_state_t     state;
  logic [9:0]     col;        // column of the last accepted pixel
  logic [8:0]     row;        // row of the last accepted pixel
  logic [9:0]     thresh;     // threshold latched at start of frame
  logic           err;
  logic           frame_done;
  logic [LAT-1:0] vpipe;      // valid flag travelling alongside the datapath
  logic [9:0]     nxt_col;
  logic [8:0]     nxt_row;
  logic           accept;
  logic           abort;
  logic           bin;

  // Coordinate of the pixel expected next while a frame is active
  always_comb begin
    nxt_col = col + 10'd1;
    nxt_row = row;
    if (col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = row + 9'd1;
    end
  end

  // A pixel enters the pipeline on an accepted SOF or an in-frame strobe;
  // a missing strobe or a stray SOF mid-frame kills the frame
  always_comb begin
    accept = ((state == S_IDLE) && i_valid && i_sof) ||
             ((state == S_ACTIVE) && i_valid && !i_sof);
    abort  = (state == S_ACTIVE) && (!i_valid || i_sof);
  end

  // Frame control FSM with registered error / done outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      thresh     <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid && i_sof) begin
            thresh <= i_thresh;
            err    <= 1'b0;
            col    <= '0;
            row    <= '0;
            state  <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (abort) begin
            err   <= 1'b1;
            state <= S_ABORT;
          end else begin
            col <= nxt_col;
            row <= nxt_row;
            if (nxt_col == COL_LAST && nxt_row == ROW_LAST) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Done once only the final pixel remains, i.e. as it leaves
          if (vpipe[LAT-2:0] == '0) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_ABORT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid shift register; an abort discards every pixel still in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      vpipe <= '0;
    else if (abort) vpipe <= '0;
    else            vpipe <= {vpipe[LAT-2:0], accept};
  end

  pixel_luma_thresh u_luma_thresh (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_r     (i_r),
    .i_g     (i_g),
    .i_b     (i_b),
    .i_thresh(thresh),
    .o_bin   (bin)
  );

`ifdef BINARIZER_MAJ3_EN
  logic [1:0]     tap;        // tap[0] = centre pixel, tap[1] = left neighbour
  logic [LAT-1:0] epipe;      // "edge column" flag aligned with the centre tap
  logic [9:0]     acc_col;
  logic           edge_px;

  // Column of the pixel being accepted this cycle
  always_comb begin
    acc_col = (state == S_IDLE) ? 10'd0 : nxt_col;
    edge_px = (acc_col == 10'd0) || (acc_col == COL_LAST);
  end

  // Window taps and edge flag; the right neighbour is the live stage output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tap   <= '0;
      epipe <= '0;
    end else begin
      tap   <= {tap[0], bin};
      epipe <= {epipe[LAT-2:0], edge_px};
    end
  end

  // Edge columns are forced low, so no window ever straddles two rows
  assign o_seq = !epipe[LAT-1] &
                 ((tap[1] & tap[0]) | (tap[1] & bin) | (tap[0] & bin));
`else
  assign o_seq = bin;
`endif

  assign o_valid      = vpipe[LAT-1];
  assign o_err        = err;
  assign o_frame_done = frame_done;

endmodule

// File: tb/tb_pixel_binarizer.sv
// tb_pixel_binarizer: directed frame sequence with random pixel content,
// checked cycle by cycle against a frame-level reference model.
module tb_pixel_binarizer;

  localparam int COL = 16;
  localparam int ROW = 8;
  localparam int N   = COL * ROW;
`ifdef BINARIZER_MAJ3_EN
  localparam int LAT = 3;
  localparam bit MAJ = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit MAJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic       sof;
  logic [9:0] r_in;
  logic [9:0] g_in;
  logic [9:0] b_in;
  logic [9:0] thr_in;
  logic       o_valid;
  logic       o_seq;
  logic       o_err;
  logic       o_frame_done;

  int checks   = 0;
  int failures = 0;

  int pr[N];
  int pg[N];
  int pb[N];
  bit expb[N];

  always #5 clk = ~clk;

  pixel_binarizer #(.IMG_COL(COL), .IMG_ROW(ROW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (vld),
    .i_sof       (sof),
    .i_r         (r_in),
    .i_g         (g_in),
    .i_b         (b_in),
    .i_thresh    (thr_in),
    .o_valid     (o_valid),
    .o_seq       (o_seq),
    .o_err       (o_err),
    .o_frame_done(o_frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic int luma(input int r, input int g, input int b);
    return (2 * r + 5 * g + b) / 8;
  endfunction

  // Pixel content: 0 flat 600, 1 random, 2 pure G=400, 3 binary pattern
  task automatic fill(input int kind);
    int pat[7] = '{0, 1, 0, 1, 1, 0, 0};
    int v;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: begin pr[i] = 600; pg[i] = 600; pb[i] = 600; end
        1: begin
          pr[i] = $urandom_range(0, 1023);
          pg[i] = $urandom_range(0, 1023);
          pb[i] = $urandom_range(0, 1023);
        end
        2: begin pr[i] = 0; pg[i] = 400; pb[i] = 0; end
        default: begin
          v = (i < 7) ? pat[i] : int'($urandom_range(0, 1));
          pr[i] = v * 1023; pg[i] = v * 1023; pb[i] = v * 1023;
        end
      endcase
    end
  endtask

  // Expected binary output per pixel, optionally majority filtered
  task automatic build_model(input int thr);
    bit raw[N];
    int c;
    for (int i = 0; i < N; i++) raw[i] = (luma(pr[i], pg[i], pb[i]) > thr);
    for (int i = 0; i < N; i++) begin
      c = i % COL;
      if (!MAJ) expb[i] = raw[i];
      else if (c == 0 || c == COL - 1) expb[i] = 1'b0;
      else expb[i] = (int'(raw[i-1]) + int'(raw[i]) + int'(raw[i+1])) >= 2;
    end
  endtask

  // cut < 0: complete frame. cut_kind 0: strobe dropped at pixel cut,
  // 1: stray SOF at pixel cut, 2: reset asserted at pixel cut
  task automatic run_frame(input string name, input int kind, input int thr,
                           input int cut, input int cut_kind);
    int p;
    bit aborted;
    bit ev;
    bit ed;
    bit ee;
    fill(kind);
    build_model(thr);
    for (int k = 0; k < N + LAT + 2; k++) begin
      if (cut >= 0 && k == cut && cut_kind == 2) begin
        chk({name, "_prerst_valid"}, o_valid, 1);
        rst = 1'b1;
        #1;
        chk({name, "_rst_valid"}, o_valid, 0);
        chk({name, "_rst_seq"}, o_seq, 0);
        chk({name, "_rst_err"}, o_err, 0);
        chk({name, "_rst_done"}, o_frame_done, 0);
      end
      if (cut >= 0 && k >= cut) begin
        vld = (cut_kind == 1 && k == cut);
        sof = vld;
        r_in = 10'd0; g_in = 10'd0; b_in = 10'd0;
      end else if (k < N) begin
        vld = 1'b1;
        sof = (k == 0);
        r_in = 10'(pr[k]); g_in = 10'(pg[k]); b_in = 10'(pb[k]);
      end else begin
        vld = 1'b0;
        sof = 1'b0;
      end
      thr_in = (k == 0) ? 10'(thr) : 10'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      if (cut_kind == 2 && k == cut) rst = 1'b0;
      p       = k - (LAT - 1);
      aborted = (cut >= 0 && k >= cut);
      ev      = !aborted && p >= 0 && p < N;
      ed      = (cut < 0) && (p == N);
      ee      = aborted && (cut_kind != 2);
      chk({name, "_valid"}, o_valid, ev);
      chk({name, "_done"}, o_frame_done, ed);
      chk({name, "_err"}, o_err, ee);
      if (ev) chk({name, "_seq"}, o_seq, expb[p]);
    end
    $display("frame %s kind=%0d thresh=%0d cut=%0d cut_kind=%0d checks=%0d",
             name, kind, thr, cut, cut_kind, checks);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sof = 1'b0;
    r_in = '0; g_in = '0; b_in = '0; thr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_seq", o_seq, 0);
    chk("reset_err", o_err, 0);
    chk("reset_done", o_frame_done, 0);
    rst = 1'b0;

    // Strobes without SOF while idle must not start a frame
    vld = 1'b1; sof = 1'b0; r_in = 10'd1023; g_in = 10'd1023; b_in = 10'd1023;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("idle_ignore_valid", o_valid, 0);
    end
    vld = 1'b0;
    @(posedge clk);
    #1;

    run_frame("full600",    0, 500, -1, 0);
    run_frame("y250_t249",  2, 249, -1, 0);
    run_frame("y250_t250",  2, 250, -1, 0);
    run_frame("random",     1, $urandom_range(200, 800), -1, 0);
    run_frame("drop",       1, $urandom_range(200, 800), 70, 0);
    run_frame("after_drop", 1, $urandom_range(200, 800), -1, 0);
    run_frame("early_sof",  1, $urandom_range(200, 800), 40, 1);
    run_frame("pattern",    3, 500, -1, 0);
    run_frame("reset_mid",  1, $urandom_range(200, 800), 60, 2);
    run_frame("after_rst",  1, $urandom_range(200, 800), -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
